// File: rtl/smg_display_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | smg_pkg                                                                     |
// | Shared types and constants for the seven-segment display arbiter.           |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
package smg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN    = 2'd1,
      SWITCH = 2'd2
   } smg_state_e;

   localparam logic [1:0]  REQ_ALERT    = 2'd0;
   localparam logic [1:0]  REQ_TXN      = 2'd1;
   localparam logic [1:0]  REQ_IDLE     = 2'd2;
   localparam logic [5:0]  BLANK_ALL    = 6'b111111;
   localparam logic [15:0] T1MS_DEFAULT = 16'd49999;

   // Lowest index wins; the alert line always dominates.
   function automatic logic [1:0] smg_highest(input logic [2:0] req);
      logic [1:0] idx;
      idx = REQ_ALERT;
      if (req[REQ_ALERT])
         idx = REQ_ALERT;
      else if (req[REQ_TXN])
         idx = REQ_TXN;
      else if (req[REQ_IDLE])
         idx = REQ_IDLE;
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/smg_display_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | smg_display_arbiter_if                                                      |
// | Requester and display-side signals of the display arbiter.                  |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
interface smg_display_arbiter_if;
   logic [2:0]  Req;
   logic [23:0] Data0;
   logic [23:0] Data1;
   logic [23:0] Data2;
   logic [5:0]  Blank0;
   logic [5:0]  Blank1;
   logic [5:0]  Blank2;
   logic [2:0]  Grant;
   logic [23:0] Disp_Data;
   logic [5:0]  Disp_Blank;
   logic        Hold_Busy;

   modport slave (
      input  Req, Data0, Data1, Data2, Blank0, Blank1, Blank2,
      output Grant, Disp_Data, Disp_Blank, Hold_Busy
   );

   modport master (
      output Req, Data0, Data1, Data2, Blank0, Blank1, Blank2,
      input  Grant, Disp_Data, Disp_Blank, Hold_Busy
   );
endinterface
`default_nettype wire

// File: rtl/smg_display_arbiter_ms_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | smg_ms_tick                                                                 |
// | Free-running 1 ms tick generator; tick is high for one clock per period.    |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module smg_ms_tick
   import smg_pkg::*;
#(
   parameter logic [15:0] T1MS = T1MS_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   logic [15:0] c1_q;
   logic [15:0] c1_d;

   always_comb begin
      tick = (c1_q == T1MS);
      c1_d = tick ? 16'd0 : c1_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         c1_q <= 16'd0;
      else
         c1_q <= c1_d;
   end

endmodule
`default_nettype wire

// File: rtl/smg_display_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | smg_display_arbiter                                                         |
// | Fixed-priority time-share of the 6-digit display with minimum hold time.    |
// | Optional alert blinking when SMG_BLINK_EN is defined.                       |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module smg_display_arbiter
   import smg_pkg::*;
#(
   parameter logic [15:0] T1MS     = T1MS_DEFAULT,
   parameter logic [15:0] HOLD_MS  = 16'd500,
   parameter logic [15:0] BLINK_MS = 16'd250
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   smg_display_arbiter_if.slave  bus
);

   smg_state_e  state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic [23:0] disp_data_q, disp_data_d;
   logic [5:0]  disp_blank_q, disp_blank_d;

   logic        tick;
   logic        hold_ok;
   logic [1:0]  win;
   logic [23:0] win_data, own_data;
   logic [5:0]  win_blank, own_blank;
   logic [2:0]  higher_mask;
   logic        higher_req;
   logic        own_req;
   logic        enter_own;

   smg_ms_tick #(.T1MS(T1MS)) u_ms_tick (
      .clk   (CLK),
      .rst_n (RSTn),
      .tick  (tick)
   );

   always_comb begin
      win = smg_highest(bus.Req);
      case (win)
         REQ_TXN:  begin win_data = bus.Data1; win_blank = bus.Blank1; end
         REQ_IDLE: begin win_data = bus.Data2; win_blank = bus.Blank2; end
         default:  begin win_data = bus.Data0; win_blank = bus.Blank0; end
      endcase
      case (owner_q)
         REQ_TXN:  begin own_data = bus.Data1; own_blank = bus.Blank1; end
         REQ_IDLE: begin own_data = bus.Data2; own_blank = bus.Blank2; end
         default:  begin own_data = bus.Data0; own_blank = bus.Blank0; end
      endcase
      higher_mask = (3'b001 << owner_q) - 3'b001;
      higher_req  = |(bus.Req & higher_mask);
      own_req     = |(bus.Req & (3'b001 << owner_q));
      hold_ok     = (hold_cnt_q >= HOLD_MS);
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      hold_cnt_d   = hold_cnt_q;
      disp_data_d  = disp_data_q;
      disp_blank_d = disp_blank_q;
      enter_own    = 1'b0;

      case (state_q)
         IDLE: begin
            disp_blank_d = BLANK_ALL;
            enter_own    = (bus.Req != 3'b000);
         end
         OWN: begin
            // Once the owner lets go, its last captured value stays frozen.
            if (own_req) begin
               disp_data_d  = own_data;
               disp_blank_d = own_blank;
            end
            if (tick && (hold_cnt_q < HOLD_MS))
               hold_cnt_d = hold_cnt_q + 16'd1;
            if (hold_ok) begin
               if (higher_req || (!own_req && (bus.Req != 3'b000))) begin
                  state_d = SWITCH;
               end else if (bus.Req == 3'b000) begin
                  state_d      = IDLE;
                  disp_blank_d = BLANK_ALL;
               end
            end
         end
         SWITCH: begin
            if (bus.Req != 3'b000) begin
               enter_own = 1'b1;
            end else begin
               state_d      = IDLE;
               disp_blank_d = BLANK_ALL;
            end
         end
         default: begin
            state_d      = IDLE;
            disp_blank_d = BLANK_ALL;
         end
      endcase

      if (enter_own) begin
         state_d      = OWN;
         owner_d      = win;
         hold_cnt_d   = 16'd0;
         disp_data_d  = win_data;
         disp_blank_d = win_blank;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= IDLE;
         owner_q      <= REQ_ALERT;
         hold_cnt_q   <= 16'd0;
         disp_data_q  <= 24'h000000;
         disp_blank_q <= BLANK_ALL;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         hold_cnt_q   <= hold_cnt_d;
         disp_data_q  <= disp_data_d;
         disp_blank_q <= disp_blank_d;
      end
   end

   assign bus.Grant     = (state_q == OWN) ? (3'b001 << owner_q) : 3'b000;
   assign bus.Disp_Data = disp_data_q;
   assign bus.Hold_Busy = (state_q == OWN) && !hold_ok;

`ifdef SMG_BLINK_EN
   logic        blink_off_q, blink_off_d;
   logic [15:0] blink_cnt_q, blink_cnt_d;

   // Phase restarts "on" whenever the alert is not the current owner.
   always_comb begin
      blink_off_d = 1'b0;
      blink_cnt_d = 16'd0;
      if ((state_q == OWN) && (owner_q == REQ_ALERT)) begin
         blink_off_d = blink_off_q;
         blink_cnt_d = blink_cnt_q;
         if (tick) begin
            if (({1'b0, blink_cnt_q} + 17'd1) >= {1'b0, BLINK_MS}) begin
               blink_off_d = !blink_off_q;
               blink_cnt_d = 16'd0;
            end else begin
               blink_cnt_d = blink_cnt_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         blink_off_q <= 1'b0;
         blink_cnt_q <= 16'd0;
      end else begin
         blink_off_q <= blink_off_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign bus.Disp_Blank = blink_off_q ? BLANK_ALL : disp_blank_q;
`else
   logic [15:0] blink_ms_unused;
   assign blink_ms_unused = BLINK_MS;
   assign bus.Disp_Blank  = disp_blank_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_smg_display_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_smg_display_arbiter                                                      |
// | Scoreboard bench: stimulus queues expected outputs by cycle, monitor checks.|
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_smg_display_arbiter;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   int   tag_n;

   smg_display_arbiter_if bus ();

   smg_display_arbiter #(
      .T1MS     (16'd9),
      .HOLD_MS  (16'd3),
      .BLINK_MS (16'd2)
   ) dut (
      .CLK  (clk),
      .RSTn (rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index since reset release; the DUT tick fires in cycles where cyc % 10 == 9.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cyc <= 0;
      else
         cyc <= cyc + 1;
   end

   // mask bits: [0] Grant, [1] Disp_Data, [2] Disp_Blank, [3] Hold_Busy
   typedef struct {
      int          due;
      logic [3:0]  mask;
      logic [2:0]  g;
      logic [23:0] d;
      logic [5:0]  b;
      logic        busy;
      int          tag;
   } exp_t;

   exp_t q[$];

   task automatic push(input int due, input logic [3:0] mask, input logic [2:0] g,
                       input logic [23:0] d, input logic [5:0] b, input logic busy);
      exp_t e;
      e.due  = due;
      e.mask = mask;
      e.g    = g;
      e.d    = d;
      e.b    = b;
      e.busy = busy;
      e.tag  = tag_n;
      tag_n  = tag_n + 1;
      q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   always @(negedge clk) begin
      checks = checks + 1;
      if ($countones(bus.Grant) > 1) begin
         errors = errors + 1;
         $display("FAIL onehot cyc=%0d Grant=%b required at most one bit set", cyc, bus.Grant);
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         e = q.pop_front();
         if (e.due < cyc) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL stale tag=%0d due=%0d now=%0d", e.tag, e.due, cyc);
         end else begin
            if (e.mask[0]) begin
               checks = checks + 1;
               if (bus.Grant !== e.g) begin
                  errors = errors + 1;
                  $display("FAIL grant tag=%0d cyc=%0d got=%b exp=%b", e.tag, cyc, bus.Grant, e.g);
               end
            end
            if (e.mask[1]) begin
               checks = checks + 1;
               if (bus.Disp_Data !== e.d) begin
                  errors = errors + 1;
                  $display("FAIL data tag=%0d cyc=%0d got=%h exp=%h", e.tag, cyc, bus.Disp_Data, e.d);
               end
            end
            if (e.mask[2]) begin
               checks = checks + 1;
               if (bus.Disp_Blank !== e.b) begin
                  errors = errors + 1;
                  $display("FAIL blank tag=%0d cyc=%0d got=%b exp=%b", e.tag, cyc, bus.Disp_Blank, e.b);
               end
            end
            if (e.mask[3]) begin
               checks = checks + 1;
               if (bus.Hold_Busy !== e.busy) begin
                  errors = errors + 1;
                  $display("FAIL busy tag=%0d cyc=%0d got=%b exp=%b", e.tag, cyc, bus.Hold_Busy, e.busy);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      tag_n  = 0;
      rst_n  = 1'b0;
      bus.Req    = 3'b000;
      bus.Data0  = 24'h987654;
      bus.Data1  = 24'h000000;
      bus.Data2  = 24'h001250;
      bus.Blank0 = 6'b000011;
      bus.Blank1 = 6'b000000;
      bus.Blank2 = 6'b110000;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Reset state, then idle banner grant
      push(0, 4'b1111, 3'b000, 24'h000000, 6'b111111, 1'b0);
      bus.Req = 3'b100;
      push(1, 4'b1111, 3'b100, 24'h001250, 6'b110000, 1'b1);
      push(5, 4'b0010, 3'b000, 24'h001250, 6'b000000, 1'b0);
      push(6, 4'b0010, 3'b000, 24'h001251, 6'b000000, 1'b0);
      wait_cyc(5);
      bus.Data2 = 24'h001251;

      // Alert arrives one tick after grant; hold expires on the third tick
      wait_cyc(10);
      bus.Req = 3'b101;
      push(29, 4'b1111, 3'b100, 24'h001251, 6'b110000, 1'b1);
      push(30, 4'b1001, 3'b100, 24'h000000, 6'b000000, 1'b0);
      push(31, 4'b1111, 3'b000, 24'h001251, 6'b110000, 1'b0);
      push(32, 4'b1111, 3'b001, 24'h987654, 6'b000011, 1'b1);
`ifdef SMG_BLINK_EN
      push(55, 4'b0101, 3'b001, 24'h000000, 6'b111111, 1'b0);
      push(75, 4'b0101, 3'b001, 24'h000000, 6'b000011, 1'b0);
      push(95, 4'b0101, 3'b001, 24'h000000, 6'b111111, 1'b0);
`else
      push(55, 4'b0101, 3'b001, 24'h000000, 6'b000011, 1'b0);
      push(75, 4'b0101, 3'b001, 24'h000000, 6'b000011, 1'b0);
      push(95, 4'b0101, 3'b001, 24'h000000, 6'b000011, 1'b0);
`endif
      // Banner request pending for 100 ticks never preempts the alert
      for (int i = 1; i <= 10; i++)
         push(32 + 100 * i, 4'b1011, 3'b001, 24'h987654, 6'b000000, 1'b0);

      wait_cyc(1040);
      bus.Req   = 3'b100;
      bus.Data2 = 24'h000777;
      push(1041, 4'b1001, 3'b000, 24'h000000, 6'b000000, 1'b0);
      push(1042, 4'b1111, 3'b100, 24'h000777, 6'b110000, 1'b1);

      // Banner drops, transaction takes over after hold
      wait_cyc(1043);
      bus.Req    = 3'b010;
      bus.Data1  = 24'h000100;
      bus.Blank1 = 6'b111000;
      push(1070, 4'b1011, 3'b100, 24'h000777, 6'b000000, 1'b0);
      push(1071, 4'b0001, 3'b000, 24'h000000, 6'b000000, 1'b0);
      push(1072, 4'b1111, 3'b010, 24'h000100, 6'b111000, 1'b1);
      wait_cyc(1075);
      bus.Data1 = 24'h000150;
      push(1076, 4'b0010, 3'b000, 24'h000150, 6'b000000, 1'b0);

      // Transaction drops after its first tick; value frozen until hold expires
      wait_cyc(1080);
      bus.Req   = 3'b000;
      bus.Data1 = 24'h000999;
      push(1085, 4'b1111, 3'b010, 24'h000150, 6'b111000, 1'b1);
      push(1099, 4'b1111, 3'b010, 24'h000150, 6'b111000, 1'b1);
      push(1100, 4'b1001, 3'b010, 24'h000000, 6'b000000, 1'b0);
      push(1101, 4'b1101, 3'b000, 24'h000000, 6'b111111, 1'b0);

      // Reset pulse while transaction owns the display
      wait_cyc(1105);
      bus.Req    = 3'b010;
      bus.Data1  = 24'h004321;
      bus.Blank1 = 6'b000000;
      push(1106, 4'b1111, 3'b010, 24'h004321, 6'b000000, 1'b1);
      wait_cyc(1110);
      rst_n = 1'b0;
      #1;
      push(0, 4'b1111, 3'b000, 24'h000000, 6'b111111, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      push(1, 4'b1111, 3'b010, 24'h004321, 6'b000000, 1'b1);
      push(2, 4'b0001, 3'b010, 24'h000000, 6'b000000, 1'b0);
      wait_cyc(5);

      repeat (3) @(posedge clk);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL unchecked tag=%0d due=%0d never reached", e.tag, e.due);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/smg_display_arbiter.md
# smg_display_arbiter

Time-shares the 6-digit seven-segment display between three requesters: alert, transaction amount/change, and idle price banner. It grants one requester at a time by fixed priority and enforces a minimum on-screen hold time in 1 ms units. It registers the winner's six BCD digits and blank mask for the display encoder and scan logic.

## Interface
Parameters:
- T1MS, 16'd49999, clocks per 1 ms tick minus one (50 MHz).
- HOLD_MS, 16'd500, minimum ms a grant is kept before a switch; 0 means switch immediately.
- BLINK_MS, 16'd250, blink half-period in ms; used only with SMG_BLINK_EN.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- Req  in  3  request per requester; bit 0 alert (highest), bit 1 transaction, bit 2 idle banner (lowest).
- Data0, Data1, Data2  in  24 each  six BCD digits; [23:20] is the leftmost digit.
- Blank0, Blank1, Blank2  in  6 each  per-digit blank; 1 = dark; bit 5 is the leftmost digit.
- Grant  out  3  one-hot grant, or all zero.
- Disp_Data  out  24  registered digits to the encoder.
- Disp_Blank  out  6  registered blank mask.
- Hold_Busy  out  1  high while the current owner's hold time has not expired.

## Operation
- ms tick: counter C1 counts 0..T1MS and wraps; tick is the single cycle where C1 == T1MS. C1 free-runs from reset.
- hold_cnt (16 bit): cleared on entry to OWN, incremented on each tick while in OWN, saturates at HOLD_MS. hold_ok = (hold_cnt >= HOLD_MS).
- States:
  - IDLE: Grant = 0; Disp_Blank = 6'b111111.
  - OWN(k): Grant[k] = 1.
  - SWITCH: Grant = 0; Disp_Data and Disp_Blank hold their values.
- IDLE → OWN(highest set Req) whenever Req != 0.
- OWN(k) while Req[k] = 1: Disp_Data and Disp_Blank reload from Data_k/Blank_k every cycle.
- OWN(k) after Req[k] falls: the last captured value is frozen. Stay in OWN until hold_ok.
- OWN(k) → SWITCH when hold_ok and either:
  - Req[k] = 0 and another Req is set, or
  - Req[j] = 1 for some j < k (preemption).
- OWN(k) → IDLE when hold_ok and Req == 0.
- A lower-priority request never preempts.
- SWITCH lasts exactly one cycle, then → OWN(highest set Req), or → IDLE if Req == 0.
- Simultaneous owner drop and higher request: one SWITCH, then the highest pending requester wins.
- Hold_Busy = (state == OWN) && !hold_ok.

## Timing
- Reset values: state IDLE, Grant 3'b000, Disp_Data 24'h000000, Disp_Blank 6'b111111, Hold_Busy 0, C1 0, hold_cnt 0.
- Grant latency: Req set before edge E in IDLE gives Grant and Disp_Data valid after E (1 clock).
- Data latency: Data_k to Disp_Data is 1 clock while owned.
- Switch latency: one SWITCH cycle between any two owners, so Grant is never two-hot and never changes owner without a zero cycle.
- Hold granularity: the hold expires on the HOLD_MS-th tick after OWN entry. Tick phase is free-running, so actual hold is between HOLD_MS−1 ms and HOLD_MS ms.
- Reset mid-operation: all state and outputs return to reset values asynchronously. Requesters must re-request; a level held high is re-granted 1 clock after RSTn rises.

## Configuration
- SMG_BLINK_EN defined:
  - A blink counter toggles phase every BLINK_MS ticks while OWN(0) (alert). Phase is cleared to "on" at OWN entry.
  - In the "off" phase, Disp_Blank = 6'b111111.
  - Other owners are steady.
- SMG_BLINK_EN undefined: the blink counter is absent and alerts display steady.

## Structure
- Package smg_pkg:
  - State encoding: IDLE = 2'd0, OWN = 2'd1, SWITCH = 2'd2.
  - Requester indices: REQ_ALERT = 0, REQ_TXN = 1, REQ_IDLE = 2.
  - Constants BLANK_ALL = 6'b111111 and default T1MS.
- Sub-module smg_ms_tick: C1 counter plus tick output, parameter T1MS. The same sub-module is reusable by the scan logic.

## Test plan
All scenarios use T1MS = 9 and HOLD_MS = 3.
- Reset, then Req = 3'b100 with Data2 = 24'h001250 → after 1 clock Grant = 3'b100, Disp_Data = 24'h001250, Disp_Blank = Blank2, Hold_Busy = 1.
- Owner 2 held, Req[0] set 1 tick after grant → no switch until the 3rd tick. Then exactly one cycle of Grant = 0, then Grant = 3'b001 with Disp_Data = Data0.
- Owner 1, Req[1] drops at tick 1 with Data1 changing afterwards → Disp_Data frozen at its last value until tick 3, then IDLE with Disp_Blank = 6'b111111.
- Owner 0 granted, Req[2] set → no preemption for 100 ticks. Req[0] drops → SWITCH, then Grant = 3'b100.
- RSTn pulsed low while in OWN(1) → outputs reset immediately. With Req[1] still high, Grant = 3'b010 one clock after release.
- SMG_BLINK_EN defined, BLINK_MS = 2, alert owned → Disp_Blank alternates 6'b111111 and Blank0 every 2 ticks; a transaction owner never blinks.
